strand_loader: RTL and testbench

//   Upstream feeder for soft_recursion_matrices. Accepts received read bits as a serial

---
 rtl/strand_loader.sv | 188 ++++++++++++++++++
 tb/tb_strand_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strand_loader.sv
// strand_loader
//   Feeds the recursion stage. Bits of a received read arrive one at a time on a
//   valid/ready stream. The loader packs each read into a DATA_WIDTH-bit strand and
//   records its length. Up to DEPTH finished reads wait in a FIFO. Each buffered read
//   gets one recursion launch. Its strand and length stay stable until the recursion
//   reports done. The read is then popped.
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_bit/valid/last/ready  serial read stream (in_last marks the final bit of a read)
//   strand, N        FIFO head: packed read (bit 0 first received) and its length
//   start_recursion  one-cycle launch pulse
//   done             recursion finished (level)
//   busy             a recursion is in flight
//   overflow_err     sticky: some read was longer than DATA_WIDTH
//   strands_done     completed recursions, wrapping 16-bit count
module strand_loader #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_bit,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] strand,
  output logic [31:0]           N,
  output logic                  start_recursion,
  input  logic                  done,
  output logic                  busy,
  output logic                  overflow_err,
  output logic [15:0]           strands_done
);

  localparam int LW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_ARM     = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, asm_full_s;
  logic [LW-1:0]         len_q, len_d, len_full_s;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [LW-1:0]         fifo_len_q  [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [15:0]           done_cnt_q;

  logic accept_s, push_s, pop_s;

  // The full condition ignores a pop on the same edge, which keeps the ready path short.
  assign in_ready = (count_q < CW'(DEPTH));
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && in_last;
  assign pop_s    = (state_q == S_RELEASE);

  // Head of FIFO presented to the recursion stage; zero when nothing is buffered
  assign strand = (count_q != CW'(0)) ? fifo_data_q[rd_ptr_q] : '0;
  assign N      = (count_q != CW'(0)) ? 32'(fifo_len_q[rd_ptr_q]) : 32'd0;

  assign overflow_err = ovf_q;
  assign strands_done = done_cnt_q;

  // Assembly: place accepted bit at index len, drop bits beyond DATA_WIDTH
  always_comb begin
    asm_full_s = asm_q;
    len_full_s = len_q;
    asm_d      = asm_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    if (accept_s) begin
      if (len_q < LW'(DATA_WIDTH)) begin
        asm_full_s[len_q] = in_bit;
        len_full_s        = len_q + LW'(1);
      end else begin
        ovf_d = 1'b1;
      end
      // The word that includes the last bit goes to the FIFO, and assembly restarts
      if (in_last) begin
        asm_d = '0;
        len_d = '0;
      end else begin
        asm_d = asm_full_s;
        len_d = len_full_s;
      end
    end
  end

  // Assembly and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  // FIFO storage, pointers and occupancy; push and pop on the same edge cancel in count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_len_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= asm_full_s;
        fifo_len_q[wr_ptr_q]  <= len_full_s;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register and completed-recursion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      done_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (pop_s) begin
        done_cnt_q <= done_cnt_q + 16'd1;
      end
    end
  end

  // FSM next state and decoded outputs; ARM exists only to mask a done left over from the previous run
  always_comb begin
    state_d         = state_q;
    start_recursion = 1'b0;
    busy            = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (count_q != CW'(0)) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        start_recursion = 1'b1;
        state_d         = S_ARM;
      end
      S_ARM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_strand_loader.sv
module tb_strand_loader;

  localparam int MODE_AUTO = 0;
  localparam int MODE_LOW  = 1;
  localparam int MODE_HIGH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_bit, in_valid, in_last, done;
  logic        in_ready, start_recursion, busy, overflow_err;
  logic [5:0]  strand;
  logic [31:0] N;
  logic [15:0] strands_done;

  strand_loader #(.DATA_WIDTH(6), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_bit          (in_bit),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .strand          (strand),
    .N               (N),
    .start_recursion (start_recursion),
    .done            (done),
    .busy            (busy),
    .overflow_err    (overflow_err),
    .strands_done    (strands_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_mode = MODE_LOW;
  int n_starts = 0;
  int last_start = 0;
  int start_gap = 0;
  int hs_cyc = 0;
  logic [5:0] exp_s_q [$];
  int         exp_n_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: advance to the next falling edge, drive done, check any launch against the scoreboard
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    else      busy_cnt = 0;
    case (done_mode)
      MODE_LOW:  done = 1'b0;
      MODE_HIGH: done = 1'b1;
      default:   done = (busy_cnt >= 3) && !done;
    endcase
    if (start_recursion) begin
      n_starts++;
      start_gap  = cyc - last_start;
      last_start = cyc;
      check_eq("sb_nonempty", 32'(exp_s_q.size() != 0), 32'(1));
      if (exp_s_q.size() != 0) begin
        check_eq("strand", 32'(strand), 32'(exp_s_q.pop_front()));
        check_eq("N", N, 32'(exp_n_q.pop_front()));
      end
    end
  endtask

  task automatic send_bit(input logic b, input logic last);
    logic ok;
    int guard;
    bit fin;
    guard = 0;
    fin = 1'b0;
    in_bit = b;
    in_valid = 1'b1;
    in_last = last;
    while (!fin) begin
      ok = in_ready;
      hs_cyc = cyc;
      tick();
      if (ok) begin
        fin = 1'b1;
      end else begin
        guard++;
        if (guard > 200) begin
          check_eq("ready_timeout", 32'(ok), 32'(1));
          fin = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_read(input logic [7:0] bits, input int len);
    logic [5:0] es;
    es = 6'd0;
    for (int k = 0; k < len; k++) begin
      send_bit(bits[k], k == len - 1);
      if (k < 6) es[k] = bits[k];
    end
    exp_s_q.push_back(es);
    exp_n_q.push_back(len > 6 ? 6 : len);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_s_q.size() != 0 || busy) && guard < 300) begin
      tick();
      guard++;
    end
    check_eq("drain_bound", 32'(guard < 300), 32'(1));
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    in_bit = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    done = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_strand", 32'(strand), 32'(0));
    check_eq("rst_N", N, 32'(0));
    check_eq("rst_start", 32'(start_recursion), 32'(0));
    check_eq("rst_ovf", 32'(overflow_err), 32'(0));
    check_eq("rst_sdone", 32'(strands_done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: single read, launch latency, hold until done
    done_mode = MODE_LOW;
    send_read(8'b0001_0101, 5);
    tick();
    tick();
    check_eq("t1_latency", 32'(last_start - hs_cyc), 32'(2));
    check_eq("t1_starts", 32'(n_starts), 32'(1));
    repeat (5) tick();
    check_eq("t1_hold_strand", 32'(strand), 32'(6'b010101));
    check_eq("t1_hold_N", N, 32'(5));
    check_eq("t1_busy", 32'(busy), 32'(1));
    check_eq("t1_sdone0", 32'(strands_done), 32'(0));
    check_eq("t1_one_start", 32'(n_starts), 32'(1));
    done_mode = MODE_AUTO;
    wait_drain();
    check_eq("t1_sdone1", 32'(strands_done), 32'(1));
    check_eq("t1_idle", 32'(busy), 32'(0));
    check_eq("t1_N0", N, 32'(0));

    // 2: overflow, sticky through a clean read
    send_read(8'b0011_1111, 8);
    wait_drain();
    check_eq("t2_ovf", 32'(overflow_err), 32'(1));
    send_read(8'b0000_0010, 2);
    wait_drain();
    check_eq("t2_ovf_sticky", 32'(overflow_err), 32'(1));
    check_eq("t2_sdone", 32'(strands_done), 32'(3));

    // 3: fill the FIFO with done held low
    done_mode = MODE_LOW;
    send_read(8'd1, 1);
    send_read(8'd0, 1);
    send_read(8'd1, 1);
    send_read(8'd1, 1);
    check_eq("t3_full_rdy", 32'(in_ready), 32'(0));
    check_eq("t3_starts", 32'(n_starts), 32'(4));
    done_mode = MODE_AUTO;
    send_read(8'd0, 1);
    wait_drain();
    check_eq("t3_sdone", 32'(strands_done), 32'(8));

    // 4: done stuck high, one launch per read, back-to-back spacing
    done_mode = MODE_HIGH;
    s0 = n_starts;
    send_read(8'd1, 1);
    send_read(8'd0, 1);
    send_read(8'd1, 1);
    wait_drain();
    check_eq("t4_starts", 32'(n_starts - s0), 32'(3));
    check_eq("t4_sdone", 32'(strands_done), 32'(11));
    check_eq("t4_gap", 32'(start_gap), 32'(5));
    done_mode = MODE_LOW;
    tick();

    // 5: reset while waiting with reads queued
    send_read(8'd1, 1);
    send_read(8'd1, 1);
    send_read(8'd0, 1);
    repeat (4) tick();
    s0 = n_starts;
    rst = 1'b1;
    #1;
    check_eq("t5_busy", 32'(busy), 32'(0));
    check_eq("t5_rdy", 32'(in_ready), 32'(1));
    check_eq("t5_strand", 32'(strand), 32'(0));
    check_eq("t5_N", N, 32'(0));
    check_eq("t5_sdone", 32'(strands_done), 32'(0));
    check_eq("t5_ovf", 32'(overflow_err), 32'(0));
    check_eq("t5_start", 32'(start_recursion), 32'(0));
    exp_s_q.delete();
    exp_n_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    check_eq("t5_no_start", 32'(n_starts - s0), 32'(0));
    done_mode = MODE_AUTO;
    send_read(8'd1, 1);
    wait_drain();
    check_eq("t5_new_start", 32'(n_starts - s0), 32'(1));
    check_eq("t5_sdone1", 32'(strands_done), 32'(1));

    // 6: enqueue on the same edge as the RELEASE pop; order must hold
    done_mode = MODE_LOW;
    s0 = n_starts;
    send_read(8'd1, 1);
    repeat (4) tick();
    send_bit(1'b0, 1'b0);
    done_mode = MODE_AUTO;
    tick();
    tick();
    send_bit(1'b1, 1'b1);
    exp_s_q.push_back(6'b000010);
    exp_n_q.push_back(2);
    wait_drain();
    check_eq("t6_starts", 32'(n_starts - s0), 32'(2));
    check_eq("t6_sdone", 32'(strands_done), 32'(3));
    check_eq("t6_empty", 32'(N), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
